tone_voice_scheduler: RTL and testbench

- Multi-voice tone engine driven by the processor's per-voice PIO registers: one 28-bit period (half-period) word and one 28-bit decode (duration) word per voice.
- A single shared decrement datapath is time-multiplexed across voices by a round-robin scheduler, one voice per clock.
- Produces one square wave per voice, per-voice active/done status and a mixed amplitude count for the audio output stage.

---
 rtl/tone_voice_pkg.sv | 25 ++
 rtl/tone_voice_update.sv | 45 ++++
 rtl/tone_voice_scheduler.sv | 88 ++++++++
 tb/tb_tone_voice_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tone_voice_pkg.sv
// Shared types and helpers for the multi-voice tone engine.
package tone_voice_pkg;

  localparam int unsigned W = 28;
  localparam int unsigned NUM_VOICES_DEFAULT = 8;

  typedef struct packed {
    logic [W-1:0] phase;
    logic [W-1:0] dur;
    logic [W-1:0] shadow_p;
    logic [W-1:0] shadow_d;
    logic         sq;
    logic         active;
  } voice_state_t;

  function automatic int unsigned popcount(input logic [63:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += int'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tone_voice_update.sv
// Combinational next-state for the single voice visited this clock.
module tone_voice_update
  import tone_voice_pkg::*;
(
  input  voice_state_t cur_i,
  input  logic [W-1:0] period_i,
  input  logic [W-1:0] decode_i,
  input  logic         round_tick_i,
  output voice_state_t nxt_o,
  output logic         done_o
);

  always_comb begin
    nxt_o  = cur_i;
    done_o = 1'b0;
    if (period_i != cur_i.shadow_p || decode_i != cur_i.shadow_d) begin
      nxt_o.shadow_p = period_i;
      nxt_o.shadow_d = decode_i;
      nxt_o.phase    = period_i;
      nxt_o.dur      = decode_i;
      nxt_o.sq       = 1'b0;
      nxt_o.active   = (period_i != '0) && (decode_i != '0);
    end else if (cur_i.active) begin
      if (cur_i.phase <= W'(1)) begin
        nxt_o.phase = cur_i.shadow_p;
        nxt_o.sq    = ~cur_i.sq;
      end else begin
        nxt_o.phase = cur_i.phase - W'(1);
      end
      if (round_tick_i) begin
        // Expiry overrides any toggle computed above.
        if (cur_i.dur == W'(1)) begin
          nxt_o.active = 1'b0;
          nxt_o.sq     = 1'b0;
          done_o       = 1'b1;
        end else begin
          nxt_o.dur = cur_i.dur - W'(1);
        end
      end
    end else begin
      nxt_o.sq = 1'b0;
    end
  end

endmodule

// File: rtl/tone_voice_scheduler.sv
// Round-robin tone engine: one shared voice update per clock, duration prescaler,
// registered square-wave, status and mix outputs.
module tone_voice_scheduler
  import tone_voice_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEFAULT,
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned MIX_W      = 4
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset_n,
  input  logic [NUM_VOICES*W-1:0] period_in,
  input  logic [NUM_VOICES*W-1:0] decode_in,
  output logic [NUM_VOICES-1:0]   voice_out,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   done_pulse,
  output logic [MIX_W-1:0]        mix_out
);

  localparam int unsigned PtrW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PtrW-1:0]       vptr_q, vptr_d;
  logic [CntW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                  tick_req_q, tick_req_d;
  logic                  round_tick_q, round_tick_d;
  voice_state_t [NUM_VOICES-1:0] st_q, st_d;
  logic [NUM_VOICES-1:0] done_q, done_d;
  logic [MIX_W-1:0]      mix_q, mix_d;
  voice_state_t          upd_nxt;
  logic                  upd_done;
  logic                  wrap;

  tone_voice_update u_update (
    .cur_i        (st_q[vptr_q]),
    .period_i     (period_in[vptr_q*W +: W]),
    .decode_i     (decode_in[vptr_q*W +: W]),
    .round_tick_i (round_tick_q),
    .nxt_o        (upd_nxt),
    .done_o       (upd_done)
  );

  always_comb begin
    wrap       = (tick_cnt_q == CntW'(TICK_DIV - 1));
    tick_cnt_d = wrap ? '0 : tick_cnt_q + CntW'(1);
    vptr_d     = (vptr_q == PtrW'(NUM_VOICES - 1)) ? '0 : vptr_q + PtrW'(1);
    // A wrap landing on the round-start clock belongs to the round being latched.
    if (vptr_q == '0) begin
      round_tick_d = tick_req_q | wrap;
      tick_req_d   = 1'b0;
    end else begin
      round_tick_d = round_tick_q;
      tick_req_d   = tick_req_q | wrap;
    end
    st_d           = st_q;
    st_d[vptr_q]   = upd_nxt;
    done_d         = '0;
    done_d[vptr_q] = upd_done;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_out[v]    = st_q[v].sq;
      voice_active[v] = st_q[v].active;
    end
    mix_d      = MIX_W'(popcount(64'(voice_out)));
    done_pulse = done_q;
    mix_out    = mix_q;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      vptr_q       <= '0;
      tick_cnt_q   <= '0;
      tick_req_q   <= 1'b0;
      round_tick_q <= 1'b0;
      st_q         <= '0;
      done_q       <= '0;
      mix_q        <= '0;
    end else begin
      vptr_q       <= vptr_d;
      tick_cnt_q   <= tick_cnt_d;
      tick_req_q   <= tick_req_d;
      round_tick_q <= round_tick_d;
      st_q         <= st_d;
      done_q       <= done_d;
      mix_q        <= mix_d;
    end
  end

endmodule

// File: tb/tb_tone_voice_scheduler.sv
// Directed and randomized bench for tone_voice_scheduler against a visit-count model.
module tb_tone_voice_scheduler;

  localparam int NV = 8;
  localparam int WW = 28;
  localparam int TD = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NV*WW-1:0] period_in, decode_in;
  logic [NV-1:0]   voice_out, voice_active, done_pulse;
  logic [3:0]      mix_out;

  tone_voice_scheduler #(.NUM_VOICES(NV), .TICK_DIV(TD), .MIX_W(4)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .period_in     (period_in),
    .decode_in     (decode_in),
    .voice_out     (voice_out),
    .voice_active  (voice_active),
    .done_pulse    (done_pulse),
    .mix_out       (mix_out)
  );

  always #5 clk = ~clk;

  int unsigned pv [NV];
  int unsigned dv [NV];
  // Model: shadowed words, visits since trigger, ticks seen since trigger.
  int unsigned sp [NV];
  int unsigned sd [NV];
  int unsigned nvis [NV];
  int unsigned tks [NV];
  bit          act [NV];
  int          c;
  logic [7:0]  exp_vo, exp_va, exp_done;
  logic [3:0]  exp_mix;
  int          passes = 0;
  int          total = 0;
  int          dn0;
  bit          saw8, saw0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic int wraps_upto(input int x);
    return (x < -1) ? 0 : (x + 1) / TD;
  endfunction

  // Round latched at edge s carries a tick if any prescaler wrap fell in edges s-7..s.
  function automatic bit tick_at(input int cc);
    int s;
    if (cc == 0) return 1'b0;
    s = ((cc - 1) / NV) * NV;
    return (wraps_upto(s) - wraps_upto(s - NV)) > 0;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      sp[v] = 0; sd[v] = 0; nvis[v] = 0; tks[v] = 0; act[v] = 1'b0;
    end
    c = 0; exp_vo = '0; exp_va = '0; exp_done = '0; exp_mix = '0;
  endtask

  task automatic drive();
    for (int v = 0; v < NV; v++) begin
      period_in[v*WW +: WW] = pv[v][WW-1:0];
      decode_in[v*WW +: WW] = dv[v][WW-1:0];
    end
  endtask

  task automatic step();
    int v;
    drive();
    @(posedge clk);
    v = c % NV;
    exp_done = '0;
    if (pv[v] != sp[v] || dv[v] != sd[v]) begin
      sp[v] = pv[v]; sd[v] = dv[v]; nvis[v] = 0; tks[v] = 0;
      act[v] = (pv[v] != 0) && (dv[v] != 0);
    end else if (act[v]) begin
      nvis[v]++;
      if (tick_at(c)) begin
        tks[v]++;
        if (tks[v] == sd[v]) begin
          act[v] = 1'b0;
          exp_done[v] = 1'b1;
        end
      end
    end
    c++;
    exp_mix = 4'($countones(exp_vo));
    for (int k = 0; k < NV; k++) begin
      exp_va[k] = act[k];
      exp_vo[k] = act[k] ? 1'(((nvis[k] / sp[k]) % 2)) : 1'b0;
    end
    #1;
    chk("voice_out", 32'(voice_out), 32'(exp_vo));
    chk("voice_active", 32'(voice_active), 32'(exp_va));
    chk("done_pulse", 32'(done_pulse), 32'(exp_done));
    chk("mix_out", 32'(mix_out), 32'(exp_mix));
    if (done_pulse[0]) dn0++;
    if (mix_out == 4'd8) saw8 = 1'b1;
    if (mix_out == 4'd0) saw0 = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vo"}, 32'(voice_out), 0);
    chk({tag, "_va"}, 32'(voice_active), 0);
    chk({tag, "_done"}, 32'(done_pulse), 0);
    chk({tag, "_mix"}, 32'(mix_out), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int v = 0; v < NV; v++) begin pv[v] = 0; dv[v] = 0; end
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single voice, period 3: 24 clocks high / 24 low.
    pv[0] = 3; dv[0] = 1000;
    run(120);
    chk("v0_active_only", 32'(voice_active), 32'h01);

    // Short note expires after 4 ticks with exactly one done pulse.
    pv[0] = 2; dv[0] = 4; dn0 = 0;
    run(120);
    chk("v0_done_once", dn0, 1);
    chk("v0_idle_after", 32'({voice_active[0], voice_out[0]}), 0);
    pv[0] = 0; dv[0] = 0;

    // Zero period or zero duration stays silent.
    pv[2] = 0; dv[2] = 50;
    run(24);
    chk("v2_zero_period", 32'({voice_active[2], voice_out[2]}), 0);
    pv[2] = 7; dv[2] = 0;
    run(24);
    chk("v2_zero_dur", 32'({voice_active[2], voice_out[2]}), 0);

    // Period change mid-note retriggers; identical rewrite does not.
    pv[3] = 5; dv[3] = 1000;
    run(100);
    pv[3] = 2;
    run(60);
    pv[3] = 2; dv[3] = 1000;
    run(60);

    // All voices period 1, aligned to a round start.
    while (c % NV != 0) step();
    for (int v = 0; v < NV; v++) begin pv[v] = 1; dv[v] = 28'hFFFFFFF; end
    saw8 = 1'b0; saw0 = 1'b0;
    run(48);
    chk("mix_reaches_8", 32'(saw8), 1);
    chk("mix_reaches_0", 32'(saw0), 1);

    // Randomized short notes.
    for (int i = 0; i < 16; i++) begin
      int v;
      v = int'($urandom_range(0, NV - 1));
      pv[v] = $urandom_range(0, 6);
      dv[v] = $urandom_range(0, 5);
      run(int'($urandom_range(8, 60)));
    end

    // Asynchronous reset mid-note clears outputs before the next edge.
    pv[1] = 3; dv[1] = 500;
    run(40);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    model_reset();
    rst_n = 1'b1;
    run(80);
    chk("retrigger_after_rst", 32'(voice_active[1]), 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
